// File: rtl/wb_timer_pkg.sv
// wb_timer shared definitions: register indices, CTRL layout, defaults.
// Byte-lane merge helper used by every writable register.
package wb_timer_pkg;

    typedef enum logic [2:0] {
        REG_MTIME_LO = 3'd0,
        REG_MTIME_HI = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_CTRL     = 3'd4
    } reg_idx_e;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_PRESC_LSB = 8;

    localparam logic [63:0] RESET_CMP_DEF = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_timer_presc.sv
// wb_timer prescaler: one tick every presc+1 cycles while enabled.
// Counter restarts from zero whenever CTRL is written.
module wb_timer_presc
    import wb_timer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] presc,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en & (cnt == presc);

    // divide counter, wraps on each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: 64-bit machine timer, Wishbone responder, level timer irq.
// Optional prescaler is built when TIMER_PRESC_EN is defined.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [63:0] RESET_CMP = RESET_CMP_DEF,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [2:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        tirq_o
);

`ifdef TIMER_PRESC_EN
    localparam bit PRESC_EN = 1'b1;
`else
    localparam bit PRESC_EN = 1'b0;
`endif

    localparam logic [31:0] PRESC_FIELD =
        32'(((64'd1 << PRESC_W) - 64'd1) << CTRL_PRESC_LSB);
    localparam logic [31:0] CTRL_MASK =
        (32'd1 << CTRL_EN) | (PRESC_EN ? PRESC_FIELD : 32'd0);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_nxt;
    logic [31:0] ctrl;
    logic [31:0] hi_shadow;
    logic [31:0] rdata;
    logic        req;
    logic        wr;
    logic        en;
    logic        tick;

    assign req = cyc_i & stb_i & ~ack_o;
    assign wr  = req & we_i;
    assign en  = ctrl[CTRL_EN];

`ifdef TIMER_PRESC_EN
    wb_timer_presc #(
        .W(PRESC_W)
    ) u_presc (
        .clk   (clk_i),
        .rst_n (rst_in),
        .en    (en),
        .clr   (wr && (adr_i == REG_CTRL)),
        .presc (ctrl[CTRL_PRESC_LSB +: PRESC_W]),
        .tick  (tick)
    );
`else
    assign tick = en;
`endif

    // next mtime: any mtime write wins over the increment for the cycle
    always_comb begin
        mtime_nxt = mtime;
        if (wr && adr_i == REG_MTIME_LO) begin
            mtime_nxt[31:0] = be_merge(mtime[31:0], dat_i, be_i);
        end else if (wr && adr_i == REG_MTIME_HI) begin
            mtime_nxt[63:32] = be_merge(mtime[63:32], dat_i, be_i);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    // read mux; MTIME_HI returns the snapshot taken by the last LO read
    always_comb begin
        rdata = 32'd0;
        case (adr_i)
            REG_MTIME_LO: rdata = mtime[31:0];
            REG_MTIME_HI: rdata = hi_shadow;
            REG_CMP_LO:   rdata = mtimecmp[31:0];
            REG_CMP_HI:   rdata = mtimecmp[63:32];
            REG_CTRL:     rdata = ctrl;
            default:      rdata = 32'd0;
        endcase
    end

    // timer state and register writes
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            mtime     <= 64'd0;
            mtimecmp  <= RESET_CMP;
            ctrl      <= 32'd0;
            hi_shadow <= 32'd0;
        end else begin
            mtime <= mtime_nxt;
            if (req && !we_i && adr_i == REG_MTIME_LO) begin
                hi_shadow <= mtime[63:32];
            end
            if (wr && adr_i == REG_CMP_LO) begin
                mtimecmp[31:0] <= be_merge(mtimecmp[31:0], dat_i, be_i);
            end
            if (wr && adr_i == REG_CMP_HI) begin
                mtimecmp[63:32] <= be_merge(mtimecmp[63:32], dat_i, be_i);
            end
            if (wr && adr_i == REG_CTRL) begin
                ctrl <= be_merge(ctrl, dat_i, be_i) & CTRL_MASK;
            end
        end
    end

    // bus response: one-cycle ack, read data held between accesses
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            ack_o <= 1'b0;
            dat_o <= 32'd0;
        end else begin
            ack_o <= req;
            if (req) begin
                dat_o <= we_i ? 32'd0 : rdata;
            end
        end
    end

    // registered compare drives the interrupt level
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            tirq_o <= 1'b0;
        end else begin
            tirq_o <= en & (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: vector tables plus corner sequences.
// Read results are matched against a scoreboard queue on each ack.
module tb_wb_timer;

    logic        clk_i = 1'b0;
    logic        rst_in = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [2:0]  adr_i = 3'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        tirq_o;

    wb_timer dut (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .be_i   (be_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .tirq_o (tirq_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef TIMER_PRESC_EN
    localparam logic [31:0] EXP_CTRL = 32'h0000_FF00;
`else
    localparam logic [31:0] EXP_CTRL = 32'h0000_0000;
`endif

    typedef struct {
        logic        chk;
        logic [31:0] lo;
        logic [31:0] hi;
        string       nm;
    } sb_t;

    typedef struct {
        logic        we;
        logic [2:0]  adr;
        logic [3:0]  be;
        logic [31:0] dat;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    sb_t  sb[$];
    vec_t tab[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk32(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h..%h",
                     nm, act, lo, hi);
        end
    endtask

    task automatic access(
        input logic        w,
        input logic [2:0]  a,
        input logic [3:0]  b,
        input logic [31:0] d,
        input logic [31:0] lo,
        input logic [31:0] hi,
        input string       nm,
        input bit          hold = 1'b0
    );
        @(negedge clk_i);
        if (ack_o) @(negedge clk_i);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = w;
        adr_i = a;
        be_i  = b;
        dat_i = d;
        sb.push_back('{chk: !w, lo: lo, hi: hi, nm: nm});
        @(posedge clk_i);
        #1;
        chk32({nm, "_ack"}, {31'd0, ack_o}, 32'd1, 32'd1);
        if (hold) begin
            @(posedge clk_i);
            #1;
            chk32({nm, "_held"}, {31'd0, ack_o}, 32'd0, 32'd0);
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        access(1'b1, a, 4'hF, d, 32'd0, 32'd0, "wr");
    endtask

    task automatic rd(
        input logic [2:0]  a,
        input logic [31:0] e,
        input string       nm
    );
        access(1'b0, a, 4'hF, 32'd0, e, e, nm);
    endtask

    task automatic run_tab();
        for (int i = 0; i < tab.size(); i++) begin
            access(tab[i].we, tab[i].adr, tab[i].be, tab[i].dat,
                   tab[i].exp, tab[i].exp, tab[i].nm);
        end
        tab.delete();
    endtask

    task automatic reset_tab();
        logic [31:0] ex [8];
        ex = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++) begin
            tab.push_back('{we: 1'b0, adr: 3'(i), be: 4'hF,
                            dat: 32'd0, exp: ex[i],
                            nm: $sformatf("rst_rd%0d", i)});
        end
        run_tab();
    endtask

    // scoreboard: pop one expectation per ack
    always @(negedge clk_i) begin
        sb_t e;
        if (rst_in && ack_o) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_extra_ack: got ack expected none");
            end else begin
                e = sb.pop_front();
                if (e.chk) chk32(e.nm, dat_o, e.lo, e.hi);
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk_i);
        #1;
        chk32("rst_ack", {31'd0, ack_o}, 32'd0, 32'd0);
        chk32("rst_dat", dat_o, 32'd0, 32'd0);
        chk32("rst_tirq", {31'd0, tirq_o}, 32'd0, 32'd0);
        @(negedge clk_i);
        rst_in = 1'b1;

        // reset values of all eight words
        reset_tab();
        chk32("t1_tirq", {31'd0, tirq_o}, 32'd0, 32'd0);

        // byte-enable writes to MTIMECMP_LO
        tab.push_back('{1'b1, 3'd2, 4'hF, 32'h1234_5678, 32'd0, "w"});
        tab.push_back('{1'b0, 3'd2, 4'hF, 32'd0, 32'h1234_5678, "cmp_full"});
        tab.push_back('{1'b1, 3'd2, 4'h5, 32'hAABB_CCDD, 32'd0, "w"});
        tab.push_back('{1'b0, 3'd2, 4'hF, 32'd0, 32'h12BB_56DD, "cmp_be5"});
        tab.push_back('{1'b1, 3'd2, 4'h0, 32'h0, 32'd0, "w"});
        tab.push_back('{1'b0, 3'd2, 4'hF, 32'd0, 32'h12BB_56DD, "cmp_be0"});
        tab.push_back('{1'b1, 3'd4, 4'hF, 32'hFFFF_FF00, 32'd0, "w"});
        tab.push_back('{1'b0, 3'd4, 4'hF, 32'd0, EXP_CTRL, "ctrl_mask"});
        tab.push_back('{1'b1, 3'd4, 4'hF, 32'h0, 32'd0, "w"});
        run_tab();

        // free-running count with a held strobe on the enable write
        access(1'b1, 3'd4, 4'hF, 32'd1, 32'd0, 32'd0, "en_hold", 1'b1);
        repeat (99) @(posedge clk_i);
        access(1'b0, 3'd0, 4'hF, 32'd0, 32'd100, 32'd102, "t2_cnt");
        wr(3'd4, 32'd0);

        // carry from LO into HI and the shadowed high word
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        repeat (2) @(posedge clk_i);
        wr(3'd4, 32'd0);
        rd(3'd0, 32'd1, "t3_lo");
        rd(3'd1, 32'd1, "t3_hi");

        // interrupt at mtime == mtimecmp
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd50);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd1);
        c = 0;
        while (!tirq_o && c < 200) begin
            @(posedge clk_i);
            #1;
            c++;
        end
        chk32("t4_rise_cyc", 32'(c), 32'd51, 32'd51);
        wr(3'd3, 32'd1);
        chk32("t4_cmp_w0", {31'd0, tirq_o}, 32'd1, 32'd1);
        @(posedge clk_i);
        #1;
        chk32("t4_cmp_w1", {31'd0, tirq_o}, 32'd0, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd0);
        chk32("t4_en_w0", {31'd0, tirq_o}, 32'd1, 32'd1);
        @(posedge clk_i);
        #1;
        chk32("t4_en_w1", {31'd0, tirq_o}, 32'd0, 32'd0);
        wr(3'd3, 32'd1);

        // partial LO write while counting drops that cycle's increment
        wr(3'd0, 32'h1122_3344);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        access(1'b1, 3'd0, 4'h2, 32'h0000_AB00, 32'd0, 32'd0, "w");
        wr(3'd4, 32'd0);
        rd(3'd0, 32'h1122_AB47, "t5_lo");
        rd(3'd1, 32'd0, "t5_hi");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, 32'd0, "t5_rsv");
        rd(3'd0, 32'h1122_AB47, "t5_lo2");

`ifdef TIMER_PRESC_EN
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'h0000_0301);
        repeat (40) @(posedge clk_i);
        access(1'b0, 3'd0, 4'hF, 32'd0, 32'd9, 32'd11, "t6_presc");
        wr(3'd4, 32'd0);
`endif

        // asynchronous reset in the middle of an acked access
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd1);
        @(negedge clk_i);
        if (ack_o) @(negedge clk_i);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        adr_i = 3'd4;
        @(posedge clk_i);
        #1;
        chk32("t6_pre_ack", {31'd0, ack_o}, 32'd1, 32'd1);
        chk32("t6_pre_dat", dat_o, 32'd1, 32'd1);
        chk32("t6_pre_tirq", {31'd0, tirq_o}, 32'd1, 32'd1);
        rst_in = 1'b0;
        #1;
        chk32("t6_rst_ack", {31'd0, ack_o}, 32'd0, 32'd0);
        chk32("t6_rst_dat", dat_o, 32'd0, 32'd0);
        chk32("t6_rst_tirq", {31'd0, tirq_o}, 32'd0, 32'd0);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        sb.delete();
        @(negedge clk_i);
        rst_in = 1'b1;
        reset_tab();
        repeat (3) @(posedge clk_i);
        chk32("sb_drained", 32'(sb.size()), 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
